// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential signed fixed-point divider (in1 / in2).
// Restoring shift-subtract core that produces one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
// Unrepresentable quotients and division by zero saturate and raise flags.
// Optional feature macro: FP_DIV_ROUND_EN adds one guard bit and rounds the
// magnitude half away from zero; without it the quotient truncates toward zero.
module fp_divider_seq #(
    parameter int WI1 = 3,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 3,
    parameter int WIO = WI1 + WF2,
    parameter int WFO = WF1 + WI2
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [WI1+WF1-1:0]     in1,
    input  logic [WI2+WF2-1:0]     in2,
    output logic                   outValid,
    input  logic                   outReady,
    output logic                   overFlow,
    output logic                   divZero,
    output logic [WIO+WFO-1:0]     FpDivOut
);

    localparam int W1 = WI1 + WF1;
    localparam int W2 = WI2 + WF2;
    localparam int S  = WFO + WF2 - WF1;
    localparam int NW = WI1 + WF1 + S;
    localparam int QW = WIO + WFO;
`ifdef FP_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int NWR = NW + RND;
    localparam int CW  = $clog2(NWR + 1);

    // Saturation limits on the magnitude, one bit wider than the quotient
    localparam logic [QW:0]   POS_LIM = {2'b00, {(QW-1){1'b1}}};
    localparam logic [QW:0]   NEG_LIM = {2'b01, {(QW-1){1'b0}}};
    localparam logic [QW-1:0] MAX_POS = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] MIN_NEG = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH, HOLD} state_t;

    state_t          state;
    state_t          nextState;

    logic            signReg;
    logic            dividendNeg;
    logic [NWR-1:0]  nReg;
    logic [W2-1:0]   dReg;
    logic [W2-1:0]   rem;
    logic [NWR-1:0]  qReg;
    logic [CW-1:0]   count;

    logic [W1-1:0]   absIn1;
    logic [W2-1:0]   absIn2;
    logic [W2:0]     remShift;
    logic            ge;
    logic [QW:0]     mag;
    logic [QW:0]     negMag;

    // Operand magnitudes; the most negative value maps onto its unsigned magnitude without wrapping
    assign absIn1   = in1[W1-1] ? (~in1 + W1'(1)) : in1;
    assign absIn2   = in2[W2-1] ? (~in2 + W2'(1)) : in2;
    assign remShift = {rem, nReg[NWR-1]};
    assign ge       = (remShift >= {1'b0, dReg});
`ifdef FP_DIV_ROUND_EN
    assign mag      = (QW+1)'(qReg[NWR-1:1]) + (QW+1)'(qReg[0]);
`else
    assign mag      = (QW+1)'(qReg);
`endif
    assign negMag   = (QW+1)'(0) - mag;

    // State register
    always_ff @(posedge clk) begin
        if (!nRst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (inValid)
                    nextState = (absIn2 == '0) ? FINISH : DIVIDE;
            end
            DIVIDE: begin
                if (count == CW'(NWR - 1))
                    nextState = FINISH;
            end
            FINISH: begin
                nextState = HOLD;
            end
            HOLD: begin
                outValid = 1'b1;
                if (outReady)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath: operand capture, one restoring iteration per cycle, then sign/saturate into the result register
    always_ff @(posedge clk) begin
        if (!nRst) begin
            signReg     <= 1'b0;
            dividendNeg <= 1'b0;
            nReg        <= '0;
            dReg        <= '0;
            rem         <= '0;
            qReg        <= '0;
            count       <= '0;
            overFlow    <= 1'b0;
            divZero     <= 1'b0;
            FpDivOut    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        signReg     <= in1[W1-1] ^ in2[W2-1];
                        dividendNeg <= in1[W1-1];
                        nReg        <= NWR'(absIn1) << (S + RND);
                        dReg        <= absIn2;
                        rem         <= '0;
                        qReg        <= '0;
                        count       <= '0;
                    end
                end
                DIVIDE: begin
                    rem   <= ge ? W2'(remShift - {1'b0, dReg}) : W2'(remShift);
                    qReg  <= {qReg[NWR-2:0], ge};
                    nReg  <= nReg << 1;
                    count <= count + CW'(1);
                end
                FINISH: begin
                    if (dReg == '0) begin
                        overFlow <= 1'b1;
                        divZero  <= 1'b1;
                        FpDivOut <= dividendNeg ? MIN_NEG : MAX_POS;
                    end else if (signReg && (mag > NEG_LIM)) begin
                        overFlow <= 1'b1;
                        divZero  <= 1'b0;
                        FpDivOut <= MIN_NEG;
                    end else if (!signReg && (mag > POS_LIM)) begin
                        overFlow <= 1'b1;
                        divZero  <= 1'b0;
                        FpDivOut <= MAX_POS;
                    end else begin
                        overFlow <= 1'b0;
                        divZero  <= 1'b0;
                        FpDivOut <= signReg ? negMag[QW-1:0] : mag[QW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq: directed and random checks of fp_divider_seq against an
// arithmetic reference model (exact rational division, then truncate or round,
// then saturate). Follows FP_DIV_ROUND_EN the same way as the design.
module tb_fp_divider_seq;

    localparam int WI1 = 3;
    localparam int WF1 = 4;
    localparam int WI2 = 4;
    localparam int WF2 = 3;
    localparam int W1  = WI1 + WF1;
    localparam int W2  = WI2 + WF2;
    localparam int QW  = (WI1 + WF2) + (WF1 + WI2);
    localparam int S   = (WF1 + WI2) + WF2 - WF1;
    localparam int NW  = W1 + S;
`ifdef FP_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic          clk = 1'b0;
    logic          nRst;
    logic          inValid;
    logic          inReady;
    logic [W1-1:0] in1;
    logic [W2-1:0] in2;
    logic          outValid;
    logic          outReady;
    logic          overFlow;
    logic          divZero;
    logic [QW-1:0] FpDivOut;

    int assertCount = 0;
    int failCount   = 0;

    fp_divider_seq dut (
        .clk      (clk),
        .nRst     (nRst),
        .inValid  (inValid),
        .inReady  (inReady),
        .in1      (in1),
        .in2      (in2),
        .outValid (outValid),
        .outReady (outReady),
        .overFlow (overFlow),
        .divZero  (divZero),
        .FpDivOut (FpDivOut)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: value(a)/value(b) scaled to the output LSB is a*2^S/b
    function automatic void model(input logic [W1-1:0] a, input logic [W2-1:0] b,
                                  output logic [QW-1:0] expOut, output logic expOvf,
                                  output logic expDz);
        longint sa, sb, num, magv, q2, posLim, negLim, val;
        bit neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        posLim = (longint'(1) << (QW - 1)) - 1;
        negLim = longint'(1) << (QW - 1);
        if (sb == 0) begin
            expDz  = 1'b1;
            expOvf = 1'b1;
            val    = (sa >= 0) ? posLim : -negLim;
        end else begin
            expDz = 1'b0;
            neg   = (sa < 0) != (sb < 0);
            num   = ((sa < 0) ? -sa : sa) * (longint'(1) << S);
            if (RND == 1) begin
                q2   = (2 * num) / ((sb < 0) ? -sb : sb);
                magv = (q2 + 1) / 2;
            end else begin
                magv = num / ((sb < 0) ? -sb : sb);
            end
            if (neg && magv > negLim) begin
                expOvf = 1'b1;
                val    = -negLim;
            end else if (!neg && magv > posLim) begin
                expOvf = 1'b1;
                val    = posLim;
            end else begin
                expOvf = 1'b0;
                val    = neg ? -magv : magv;
            end
        end
        expOut = QW'(val);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, measure latency, check result, optional backpressure, handshake
    task automatic applyStimulus(input logic [W1-1:0] a, input logic [W2-1:0] b, input int holdCycles);
        logic [QW-1:0] expOut;
        logic          expOvf;
        logic          expDz;
        int            lat;
        int            expLat;
        model(a, b, expOut, expOvf, expDz);
        expLat = (b == '0) ? 2 : NW + 2 + RND;
        @(negedge clk);
        in1      = a;
        in2      = b;
        inValid  = 1'b1;
        outReady = 1'b0;
        checkOutput("inReadyIdle", 32'(inReady), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            inValid = 1'b0;
            in1     = W1'($urandom);
            in2     = W2'($urandom);
        end while (!outValid && lat < 100);
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("quotient", 32'(FpDivOut), 32'(expOut));
        checkOutput("overFlow", 32'(overFlow), 32'(expOvf));
        checkOutput("divZero", 32'(divZero), 32'(expDz));
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("holdValid", 32'(outValid), 32'd1);
            checkOutput("holdInReady", 32'(inReady), 32'd0);
            checkOutput("holdQuotient", 32'(FpDivOut), 32'(expOut));
            checkOutput("holdOverFlow", 32'(overFlow), 32'(expOvf));
        end
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("postHandshakeValid", 32'(outValid), 32'd0);
        checkOutput("postHandshakeInReady", 32'(inReady), 32'd1);
        checkOutput("postHandshakeQuotient", 32'(FpDivOut), 32'(expOut));
    endtask

    initial begin
        nRst     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        in1      = '0;
        in2      = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetInReady", 32'(inReady), 32'd1);
        checkOutput("resetOutValid", 32'(outValid), 32'd0);
        checkOutput("resetOverFlow", 32'(overFlow), 32'd0);
        checkOutput("resetDivZero", 32'(divZero), 32'd0);
        checkOutput("resetQuotient", 32'(FpDivOut), 32'd0);
        @(negedge clk);
        nRst = 1'b1;

        $display("[TB] directed divisions");
        applyStimulus(7'h18, 7'h04, 0);
        applyStimulus(7'h70, 7'h0F, 0);
        applyStimulus(7'h40, 7'h7F, 0);
        applyStimulus(7'h40, 7'h01, 0);
        applyStimulus(7'h18, 7'h00, 0);
        applyStimulus(7'h70, 7'h00, 0);
        applyStimulus(7'h00, 7'h00, 0);
        applyStimulus(7'h3F, 7'h40, 0);
        applyStimulus(7'h00, 7'h45, 0);
        applyStimulus(7'h3F, 7'h01, 0);

        $display("[TB] backpressure");
        applyStimulus(7'h70, 7'h0F, 5);

        $display("[TB] random divisions");
        for (int i = 0; i < 40; i++) begin
            logic [W2-1:0] b;
            b = W2'($urandom);
            if (i % 5 == 0)
                b = W2'($urandom_range(0, 3));
            applyStimulus(W1'($urandom), b, $urandom_range(0, 2));
        end

        $display("[TB] reset during divide");
        applyStimulus(7'h18, 7'h04, 0);
        @(negedge clk);
        in1     = 7'h2B;
        in2     = 7'h05;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        nRst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midResetInReady", 32'(inReady), 32'd1);
        checkOutput("midResetOutValid", 32'(outValid), 32'd0);
        checkOutput("midResetQuotient", 32'(FpDivOut), 32'd0);
        checkOutput("midResetOverFlow", 32'(overFlow), 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        applyStimulus(7'h18, 7'h04, 0);
        checkOutput("afterResetQuotient", 32'(FpDivOut), 32'h0300);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
